writeback_arbiter: RTL and testbench

//  N-channel buffered writeback merge stage between the functional units (FX, LdSt, FP, Branch, ...) and the register file.
//  - Each unit pushes completed results into its own FIFO with a valid/ready handshake.
//  - A round-robin arbiter drains one entry per cycle into a registered writeback slot that the regfile accepts with wbReady_i.
//  - Replaces the fixed two-unit, unbuffered, no-backpressure merge with a parametrised, stallable one.

---
 rtl/writeback_arbiter_pkg.sv | 41 ++++
 rtl/writeback_arbiter_fifo.sv | 50 +++++
 rtl/writeback_arbiter.sv | 135 +++++++++++++
 tb/tb_writeback_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the writeback merge stage: functional-unit codes,
// default field widths and the packed writeback entry layout.
package writeback_arbiter_pkg;

    typedef enum logic [2:0] {
        FU_FX   = 3'd0,
        FU_FP   = 3'd1,
        FU_LDST = 3'd2,
        FU_BR   = 3'd3,
        FU_TRAP = 3'd4
    } fu_code_e;

    localparam int unsigned NUM_UNITS_DEF = 4;
    localparam int unsigned DEPTH_DEF     = 4;
    localparam int unsigned REG_W_DEF     = 5;
    localparam int unsigned DATA_W_DEF    = 64;
    localparam int unsigned FU_CODE_W_DEF = 3;
    localparam int unsigned CR_W          = 32;

    // Entry layout, MSB first: fu_code, reg1_en, reg2_en, reg1_addr, reg2_addr,
    // reg1_val, reg2_val, cr_en, cr_val.
    function automatic int unsigned entry_width(input int unsigned fu_w,
                                                input int unsigned reg_w,
                                                input int unsigned data_w);
        return fu_w + 3 + 2 * reg_w + 2 * data_w + CR_W;
    endfunction

    localparam int unsigned ENTRY_W = entry_width(FU_CODE_W_DEF, REG_W_DEF, DATA_W_DEF);

    // Field offsets (LSB positions) for the default widths.
    localparam int unsigned CR_VAL_LSB   = 0;
    localparam int unsigned CR_EN_LSB    = CR_VAL_LSB + CR_W;
    localparam int unsigned REG2_VAL_LSB = CR_EN_LSB + 1;
    localparam int unsigned REG1_VAL_LSB = REG2_VAL_LSB + DATA_W_DEF;
    localparam int unsigned REG2_ADR_LSB = REG1_VAL_LSB + DATA_W_DEF;
    localparam int unsigned REG1_ADR_LSB = REG2_ADR_LSB + REG_W_DEF;
    localparam int unsigned REG2_EN_LSB  = REG1_ADR_LSB + REG_W_DEF;
    localparam int unsigned REG1_EN_LSB  = REG2_EN_LSB + 1;
    localparam int unsigned FU_CODE_LSB  = REG1_EN_LSB + 1;

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// Synchronous per-unit result FIFO; head is presented combinationally.
module wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head_c,
    output logic             full_c,
    output logic             empty_c
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             wr_en;
    logic             rd_en;

    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == '0);
    assign wr_en   = push & ~full_c;
    assign rd_en   = pop & ~empty_c;
    assign head_c  = mem[rd_ptr];

    // Storage needs no reset: a cleared count hides any stale entries.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// N-channel buffered writeback merge: per-unit FIFOs drained round-robin into
// a single registered, stallable writeback slot.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned NUM_UNITS   = NUM_UNITS_DEF,
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned regWidth    = REG_W_DEF,
    parameter int unsigned dataWidth   = DATA_W_DEF,
    parameter int unsigned fuCodeWidth = FU_CODE_W_DEF
) (
    input  logic                             clock_i,
    input  logic                             reset_i,
    input  logic [NUM_UNITS-1:0]             unitValid_i,
    output logic [NUM_UNITS-1:0]             unitReady_o,
    input  logic [NUM_UNITS*fuCodeWidth-1:0] unitFuCode_i,
    input  logic [NUM_UNITS-1:0]             unitReg1En_i,
    input  logic [NUM_UNITS-1:0]             unitReg2En_i,
    input  logic [NUM_UNITS*regWidth-1:0]    unitReg1Addr_i,
    input  logic [NUM_UNITS*regWidth-1:0]    unitReg2Addr_i,
    input  logic [NUM_UNITS*dataWidth-1:0]   unitReg1Val_i,
    input  logic [NUM_UNITS*dataWidth-1:0]   unitReg2Val_i,
    input  logic [NUM_UNITS-1:0]             unitCrEn_i,
    input  logic [NUM_UNITS*CR_W-1:0]        unitCrVal_i,
    output logic                             wbValid_o,
    input  logic                             wbReady_i,
    output logic [fuCodeWidth-1:0]           functionalUnitCode_o,
    output logic                             reg1WritebackEnable_o,
    output logic                             reg2WritebackEnable_o,
    output logic [regWidth-1:0]              reg1WritebackAddress_o,
    output logic [regWidth-1:0]              reg2WritebackAddress_o,
    output logic [dataWidth-1:0]             reg1WritebackVal_o,
    output logic [dataWidth-1:0]             reg2WritebackVal_o,
    output logic                             condRegUpdateEnable_o,
    output logic [CR_W-1:0]                  newCRVal_o,
    output logic [$clog2(NUM_UNITS)-1:0]     wbUnit_o
);
    localparam int unsigned EW = entry_width(fuCodeWidth, regWidth, dataWidth);
    localparam int unsigned UW = $clog2(NUM_UNITS);

    logic [EW-1:0]        wr_entry [NUM_UNITS];
    logic [EW-1:0]        head_c   [NUM_UNITS];
    logic [NUM_UNITS-1:0] full_c;
    logic [NUM_UNITS-1:0] empty_c;
    logic [NUM_UNITS-1:0] push_c;
    logic [NUM_UNITS-1:0] pop_c;

    logic                 load_c;
    logic                 found_c;
    logic [UW-1:0]        winner_c;
    logic [UW-1:0]        rr_next_c;
    logic [UW-1:0]        rr_ptr;
    logic [EW-1:0]        slot_q;

    assign unitReady_o = ~full_c;
    assign push_c      = unitValid_i & ~full_c;
    assign load_c      = ~wbValid_o | wbReady_i;

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        assign wr_entry[u] = {unitFuCode_i[u*fuCodeWidth +: fuCodeWidth],
                              unitReg1En_i[u],
                              unitReg2En_i[u],
                              unitReg1Addr_i[u*regWidth +: regWidth],
                              unitReg2Addr_i[u*regWidth +: regWidth],
                              unitReg1Val_i[u*dataWidth +: dataWidth],
                              unitReg2Val_i[u*dataWidth +: dataWidth],
                              unitCrEn_i[u],
                              unitCrVal_i[u*CR_W +: CR_W]};

        wb_fifo #(
            .WIDTH (EW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clock_i),
            .rst     (reset_i),
            .push    (push_c[u]),
            .pop     (pop_c[u]),
            .wdata   (wr_entry[u]),
            .head_c  (head_c[u]),
            .full_c  (full_c[u]),
            .empty_c (empty_c[u])
        );
    end

    // Round-robin search: first non-empty FIFO at or above rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        found_c  = 1'b0;
        winner_c = '0;
        idx      = 0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            idx = (32'(rr_ptr) + i) % NUM_UNITS;
            if (!found_c && !empty_c[UW'(idx)]) begin
                found_c  = 1'b1;
                winner_c = UW'(idx);
            end
        end
    end

    always_comb begin
        pop_c = '0;
        if (load_c && found_c) begin
            pop_c[winner_c] = 1'b1;
        end
        rr_next_c = (winner_c == UW'(NUM_UNITS - 1)) ? '0 : winner_c + UW'(1);
    end

    // Writeback slot; fields hold when nothing is available to load.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wbValid_o <= 1'b0;
            slot_q    <= '0;
            wbUnit_o  <= '0;
            rr_ptr    <= '0;
        end else if (load_c) begin
            wbValid_o <= found_c;
            if (found_c) begin
                slot_q   <= head_c[winner_c];
                wbUnit_o <= winner_c;
                rr_ptr   <= rr_next_c;
            end
        end
    end

    assign {functionalUnitCode_o,
            reg1WritebackEnable_o,
            reg2WritebackEnable_o,
            reg1WritebackAddress_o,
            reg2WritebackAddress_o,
            reg1WritebackVal_o,
            reg2WritebackVal_o,
            condRegUpdateEnable_o,
            newCRVal_o} = slot_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus random traffic, checked
// every cycle against a queue-based transaction model.
module tb_writeback_arbiter;
    localparam int NU    = 4;
    localparam int DEPTH = 4;
    localparam int RW    = 5;
    localparam int DW    = 64;
    localparam int FW    = 3;
    localparam int EW    = FW + 3 + 2 * RW + 2 * DW + 32;

    logic              clock_i = 1'b0;
    logic              reset_i;
    logic [NU-1:0]     unitValid_i;
    logic [NU-1:0]     unitReady_o;
    logic [NU*FW-1:0]  unitFuCode_i;
    logic [NU-1:0]     unitReg1En_i;
    logic [NU-1:0]     unitReg2En_i;
    logic [NU*RW-1:0]  unitReg1Addr_i;
    logic [NU*RW-1:0]  unitReg2Addr_i;
    logic [NU*DW-1:0]  unitReg1Val_i;
    logic [NU*DW-1:0]  unitReg2Val_i;
    logic [NU-1:0]     unitCrEn_i;
    logic [NU*32-1:0]  unitCrVal_i;
    logic              wbValid_o;
    logic              wbReady_i;
    logic [FW-1:0]     functionalUnitCode_o;
    logic              reg1WritebackEnable_o;
    logic              reg2WritebackEnable_o;
    logic [RW-1:0]     reg1WritebackAddress_o;
    logic [RW-1:0]     reg2WritebackAddress_o;
    logic [DW-1:0]     reg1WritebackVal_o;
    logic [DW-1:0]     reg2WritebackVal_o;
    logic              condRegUpdateEnable_o;
    logic [31:0]       newCRVal_o;
    logic [1:0]        wbUnit_o;

    writeback_arbiter dut (
        .clock_i                (clock_i),
        .reset_i                (reset_i),
        .unitValid_i            (unitValid_i),
        .unitReady_o            (unitReady_o),
        .unitFuCode_i           (unitFuCode_i),
        .unitReg1En_i           (unitReg1En_i),
        .unitReg2En_i           (unitReg2En_i),
        .unitReg1Addr_i         (unitReg1Addr_i),
        .unitReg2Addr_i         (unitReg2Addr_i),
        .unitReg1Val_i          (unitReg1Val_i),
        .unitReg2Val_i          (unitReg2Val_i),
        .unitCrEn_i             (unitCrEn_i),
        .unitCrVal_i            (unitCrVal_i),
        .wbValid_o              (wbValid_o),
        .wbReady_i              (wbReady_i),
        .functionalUnitCode_o   (functionalUnitCode_o),
        .reg1WritebackEnable_o  (reg1WritebackEnable_o),
        .reg2WritebackEnable_o  (reg2WritebackEnable_o),
        .reg1WritebackAddress_o (reg1WritebackAddress_o),
        .reg2WritebackAddress_o (reg2WritebackAddress_o),
        .reg1WritebackVal_o     (reg1WritebackVal_o),
        .reg2WritebackVal_o     (reg2WritebackVal_o),
        .condRegUpdateEnable_o  (condRegUpdateEnable_o),
        .newCRVal_o             (newCRVal_o),
        .wbUnit_o               (wbUnit_o)
    );

    always #5 clock_i = ~clock_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Driven entry per unit and the transaction-level reference model.
    logic [EW-1:0] ent [NU];
    logic [EW-1:0] q [NU][$];
    logic          m_valid;
    logic [EW-1:0] m_slot;
    int            m_unit;
    int            m_rr;
    logic [NU-1:0] last_push;

    task automatic compare(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] rand_entry();
        return EW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    task automatic apply();
        for (int u = 0; u < NU; u++) begin
            {unitFuCode_i[u*FW +: FW], unitReg1En_i[u], unitReg2En_i[u],
             unitReg1Addr_i[u*RW +: RW], unitReg2Addr_i[u*RW +: RW],
             unitReg1Val_i[u*DW +: DW], unitReg2Val_i[u*DW +: DW],
             unitCrEn_i[u], unitCrVal_i[u*32 +: 32]} = ent[u];
        end
    endtask

    task automatic check_all();
        logic [NU-1:0] rdy;
        logic [EW-1:0] obs;
        for (int u = 0; u < NU; u++) rdy[u] = (q[u].size() != DEPTH);
        obs = {functionalUnitCode_o, reg1WritebackEnable_o, reg2WritebackEnable_o,
               reg1WritebackAddress_o, reg2WritebackAddress_o, reg1WritebackVal_o,
               reg2WritebackVal_o, condRegUpdateEnable_o, newCRVal_o};
        compare("ready", 256'(unitReady_o), 256'(rdy));
        compare("wb_valid", 256'(wbValid_o), 256'(m_valid));
        compare("slot_fields", 256'(obs), 256'(m_slot));
        compare("wb_unit", 256'(wbUnit_o), 256'(m_unit));
    endtask

    // Advance one clock: update the model from the pre-edge inputs, then check.
    task automatic step();
        logic [NU-1:0] psh;
        bit            found;
        int            idx;
        for (int u = 0; u < NU; u++) psh[u] = unitValid_i[u] && (q[u].size() != DEPTH);
        if (reset_i) begin
            for (int u = 0; u < NU; u++) q[u].delete();
            m_valid = 1'b0;
            m_slot  = '0;
            m_unit  = 0;
            m_rr    = 0;
            psh     = '0;
        end else begin
            if (!m_valid || wbReady_i) begin
                found = 0;
                for (int i = 0; i < NU; i++) begin
                    idx = (m_rr + i) % NU;
                    if (!found && q[idx].size() > 0) begin
                        found  = 1;
                        m_slot = q[idx].pop_front();
                        m_unit = idx;
                        m_rr   = (idx + 1) % NU;
                    end
                end
                m_valid = found;
            end
            for (int u = 0; u < NU; u++) if (psh[u]) q[u].push_back(ent[u]);
        end
        last_push = psh;
        apply();
        @(posedge clock_i);
        @(negedge clock_i);
        check_all();
    endtask

    initial begin
        int acc;
        reset_i     = 1'b1;
        unitValid_i = '0;
        wbReady_i   = 1'b0;
        m_valid     = 1'b0;
        m_slot      = '0;
        m_unit      = 0;
        m_rr        = 0;
        for (int u = 0; u < NU; u++) ent[u] = rand_entry();
        apply();
        @(negedge clock_i);

        // Reset held two cycles with every unit valid.
        unitValid_i = '1;
        step();
        step();
        reset_i     = 1'b0;
        unitValid_i = '0;
        compare("rst_ready", 256'(unitReady_o), 256'(4'b1111));
        compare("rst_valid", 256'(wbValid_o), 256'(0));
        step();
        compare("rst_nothing_queued", 256'(wbValid_o), 256'(0));

        // Fairness from pointer 0.
        wbReady_i   = 1'b1;
        unitValid_i = '1;
        for (int u = 0; u < NU; u++) ent[u] = rand_entry();
        step();
        unitValid_i = '0;
        for (int k = 0; k < NU; k++) begin
            step();
            compare("rr_from0_unit", 256'(wbUnit_o), 256'(k));
            compare("rr_from0_valid", 256'(wbValid_o), 256'(1));
        end

        // Single push from unit 2.
        unitValid_i[2] = 1'b1;
        ent[2] = {3'd3, 1'b1, 1'b0, 5'd7, 5'd0, 64'hDEAD, 64'h0, 1'b0, 32'h0};
        step();
        unitValid_i = '0;
        step();
        compare("single_valid", 256'(wbValid_o), 256'(1));
        compare("single_addr", 256'(reg1WritebackAddress_o), 256'(7));
        compare("single_val", 256'(reg1WritebackVal_o), 256'(64'hDEAD));
        compare("single_unit", 256'(wbUnit_o), 256'(2));

        // Fairness from pointer 3.
        unitValid_i = '1;
        for (int u = 0; u < NU; u++) ent[u] = rand_entry();
        step();
        unitValid_i = '0;
        for (int k = 0; k < NU; k++) begin
            step();
            compare("rr_from3_unit", 256'(wbUnit_o), 256'((k + 3) % NU));
        end
        step();

        // Backpressure: unit 0 offers six entries with the regfile stalled.
        wbReady_i      = 1'b0;
        unitValid_i[0] = 1'b1;
        ent[0] = rand_entry();
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (last_push[0]) begin
                acc++;
                ent[0] = rand_entry();
            end
        end
        compare("bp_accepted", 256'(acc), 256'(5));
        compare("bp_ready0", 256'(unitReady_o[0]), 256'(0));
        wbReady_i = 1'b1;
        for (int k = 0; k < 10 && acc < 6; k++) begin
            step();
            if (last_push[0]) acc++;
        end
        compare("bp_sixth", 256'(acc), 256'(6));
        unitValid_i = '0;
        for (int k = 0; k < 7; k++) step();

        // Full FIFO popped in the same cycle it is offered a new entry.
        wbReady_i      = 1'b0;
        unitValid_i[1] = 1'b1;
        ent[1] = rand_entry();
        for (int k = 0; k < 8; k++) begin
            step();
            if (last_push[1]) ent[1] = rand_entry();
        end
        compare("full_ready1_low", 256'(unitReady_o[1]), 256'(0));
        wbReady_i = 1'b1;
        step();
        compare("full_no_push", 256'(last_push[1]), 256'(0));
        compare("full_ready1_rises", 256'(unitReady_o[1]), 256'(1));
        unitValid_i = '0;
        for (int k = 0; k < 7; k++) step();

        // Mid-stream reset discards slot and buffered entries.
        wbReady_i   = 1'b0;
        unitValid_i = '1;
        for (int u = 0; u < NU; u++) ent[u] = rand_entry();
        step();
        unitValid_i = '0;
        step();
        reset_i = 1'b1;
        step();
        reset_i   = 1'b0;
        wbReady_i = 1'b1;
        compare("midrst_valid", 256'(wbValid_o), 256'(0));
        for (int k = 0; k < 5; k++) begin
            step();
            compare("midrst_nothing", 256'(wbValid_o), 256'(0));
        end

        // Random traffic with random regfile stalls.
        for (int c = 0; c < 400; c++) begin
            wbReady_i = ($urandom_range(0, 9) < 6);
            step();
            for (int u = 0; u < NU; u++) begin
                if (last_push[u] || !unitValid_i[u]) begin
                    unitValid_i[u] = ($urandom_range(0, 2) != 0);
                    ent[u] = rand_entry();
                end
            end
        end
        unitValid_i = '0;
        wbReady_i   = 1'b1;
        for (int k = 0; k < 20; k++) step();
        compare("drained", 256'(wbValid_o), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
